speech_phoneme_queue: RTL and testbench
=======================================

// Module: speech_phoneme_queue
// PURPOSE
//  CPU-side phoneme queue feeding speech_subsystem. 68k writes phoneme codes into a
//  FIFO through the VoiceControl_H decode window and returns immediately. A playback
//  sequencer pops codes and handshakes each one with the synthesiser
//  (phoneme_sel / start_phoneme_output / phoneme_speech_finish).
//  Supplies VoiceDtack_L to Dtack_Generator_Verilog and an optional end-of-utterance IRQ.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >=2
//  PHONEME_W  8   phoneme code width
// PORTS
//  Clk                    in   1   system clock; all logic on posedge Clk
//  Reset_L                in   1   asynchronous, active-low reset
//  VoiceControl_H         in   1   address-decoder select for this block
//  AS_L                   in   1   68k address strobe
//  RW                     in   1   1=read, 0=write
//  LDS_L                  in   1   lower data strobe; writes act only when low
//  Address                in   2   Address[2:1]: 00=DATA/STATUS, 01=CONTROL, others read 0 / write ignored
//  DataIn                 in   16  CPU write data
//  DataOut                out  16  read data; 16'h0000 when not selected for a read
//  VoiceDtack_L           out  1   bus acknowledge, active low
//  VoiceIRQ_L             out  1   interrupt request, active low
//  phoneme_sel            out  PHONEME_W  code presented to synthesiser
//  start_phoneme_output   out  1   one-Clk start pulse
//  phoneme_speech_busy    in   1   synthesiser busy
//  phoneme_speech_finish  in   1   one-cycle completion pulse
// BEHAVIOUR
//  Reset: VoiceDtack_L=1, VoiceIRQ_L=1, DataOut=0, phoneme_sel=0, start=0; FIFO empty;
//   CONTROL=0; done=0; both FSMs idle.
//  Bus FSM B_IDLE->B_ACK->B_HOLD:
//   B_IDLE: VoiceControl_H & ~AS_L -> perform access exactly once, go B_ACK.
//   Exception: write to DATA while full -> stay B_IDLE (wait-state) until a pop frees space.
//   B_ACK: VoiceDtack_L=0, DataOut valid -> B_HOLD. B_HOLD: Dtack stays 0 until AS_L=1,
//   then Dtack=1, -> B_IDLE. Latency select->Dtack low = 2 Clk.
//  Registers:
//   DATA write (LDS_L=0): push DataIn[PHONEME_W-1:0].
//   STATUS read: [15:8]=count (zero-extended); [3]=done; [2]=playing; [1]=full; [0]=empty.
//   Reading STATUS clears done at the B_HOLD->B_IDLE transition.
//   CONTROL write: bit0 flush (self-clearing), bit1 irq_en. CONTROL read: {14'b0,irq_en,1'b0}.
//  Play FSM P_IDLE->P_START->P_PLAY:
//   P_IDLE: ~empty & ~phoneme_speech_busy -> pop head into phoneme_sel, go P_START.
//   P_START: start_phoneme_output=1 for exactly one Clk -> P_PLAY.
//   P_PLAY: phoneme_speech_finish -> P_IDLE; if FIFO now empty, set done.
//   playing = (state != P_IDLE).
//  Simultaneous push and pop: count unchanged; both data paths honoured.
//  Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1; never exceeds DEPTH, never below 0.
//  Flush: pointers/count to 0 next Clk. The phoneme in P_START/P_PLAY completes normally;
//   done is set when that phoneme finishes.
//  VoiceIRQ_L = ~(done & irq_en), registered.
//  Reset mid-operation: all state returns to reset values immediately; a pending start is dropped.
// STRUCTURE
//  speech_pkg: bus/play state enums, register offsets (REG_DATA=2'b00, REG_CTRL=2'b01),
//   status bit indices.
//  Sub-module sync_fifo #(DEPTH,WIDTH): push/pop/flush, full/empty/count, async active-low reset.
//  Top level: bus FSM, register mux, play FSM, IRQ flop.
// TESTING
//  1 Reset, then write 8'h2A to DATA -> Dtack low 2 Clk after AS_L low; start pulse 1 Clk
//    with phoneme_sel=8'h2A.
//  2 Push 3 codes, finish pulse after each -> 3 starts in order; done=1; STATUS read 16'h0009;
//    second STATUS read returns 16'h0001.
//  3 Fill 16 while busy=1, 17th write -> Dtack held high; release busy, one pop -> 17th accepted;
//    count=16.
//  4 irq_en=1, play 1 code -> VoiceIRQ_L low after finish; STATUS read -> VoiceIRQ_L high.
//  5 Queue 5, flush during P_PLAY -> current finishes; no further starts; count=0.
//  6 Assert Reset_L=0 during P_START -> start=0 and Dtack high immediately; FIFO empty afterward.

Source files
------------

// File: rtl/speech_phoneme_queue_pkg.sv
// Shared constants for the speech phoneme queue: FSM state codes, register offsets
// and STATUS/CONTROL bit positions.
package speech_phoneme_queue_pkg;

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_ACK   = 2'd1;
    localparam logic [1:0] B_HOLD  = 2'd2;

    localparam logic [1:0] P_IDLE  = 2'd0;
    localparam logic [1:0] P_START = 2'd1;
    localparam logic [1:0] P_PLAY  = 2'd2;

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_CTRL = 2'b01;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_PLAYING   = 2;
    localparam int ST_DONE      = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    function automatic logic [15:0] ctrl_readback(input logic irq_en);
        return {14'b0, irq_en, 1'b0};
    endfunction

endpackage

// File: rtl/speech_phoneme_queue_if.sv
// 68k-side bus bundle for the phoneme queue: the CPU drives the master side,
// the queue answers on the slave side.
interface speech_phoneme_queue_if;
    logic        VoiceControl_H;
    logic        AS_L;
    logic        RW;
    logic        LDS_L;
    logic [1:0]  Address;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        VoiceDtack_L;

    modport master (
        output VoiceControl_H, AS_L, RW, LDS_L, Address, DataIn,
        input  DataOut, VoiceDtack_L
    );

    modport slave (
        input  VoiceControl_H, AS_L, RW, LDS_L, Address, DataIn,
        output DataOut, VoiceDtack_L
    );
endinterface

// File: rtl/speech_phoneme_queue_sync_fifo.sv
// Single-clock FIFO with flush; occupancy counter is one bit wider than the
// pointers so full and empty are distinguished without a spare slot.
module speech_phoneme_queue_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/speech_phoneme_queue.sv
// CPU phoneme queue: 68k bus slave that pushes codes into a FIFO, plus a playback
// sequencer that hands each code to the synthesiser and flags end of utterance.
module speech_phoneme_queue
    import speech_phoneme_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PHONEME_W = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_L,
    speech_phoneme_queue_if.slave bus,
    output logic                  VoiceIRQ_L,
    output logic [PHONEME_W-1:0]  phoneme_sel,
    output logic                  start_phoneme_output,
    input  logic                  phoneme_speech_busy,
    input  logic                  phoneme_speech_finish
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]           r_bus_state;
    logic [1:0]           r_play_state;
    logic                 r_dtack_n;
    logic                 r_irq_n;
    logic                 r_irq_en;
    logic                 r_done;
    logic                 r_status_rd;
    logic [15:0]          r_rd_data;
    logic [PHONEME_W-1:0] r_phoneme;

    logic                 w_sel;
    logic                 w_data_wr;
    logic                 w_stall;
    logic                 w_access;
    logic                 w_push;
    logic                 w_ctrl_wr;
    logic                 w_flush;
    logic                 w_pop;
    logic                 w_done_clr;
    logic                 w_full;
    logic                 w_empty;
    logic [PHONEME_W-1:0] w_head;
    logic [CNT_W-1:0]     w_count;
    logic [15:0]          w_status;
    logic [15:0]          w_rd_mux;
    logic                 w_unused_data;

    // A DATA write that would overflow is not acknowledged; the CPU simply waits.
    assign w_sel      = bus.VoiceControl_H & ~bus.AS_L & (r_bus_state == B_IDLE);
    assign w_data_wr  = ~bus.RW & ~bus.LDS_L & (bus.Address == REG_DATA);
    assign w_stall    = w_data_wr & w_full;
    assign w_access   = w_sel & ~w_stall;
    assign w_push     = w_access & w_data_wr;
    assign w_ctrl_wr  = w_access & ~bus.RW & ~bus.LDS_L & (bus.Address == REG_CTRL);
    assign w_flush    = w_ctrl_wr & bus.DataIn[CTRL_FLUSH];
    assign w_pop      = (r_play_state == P_IDLE) & ~w_empty & ~phoneme_speech_busy;
    assign w_done_clr = (r_bus_state == B_HOLD) & bus.AS_L & r_status_rd;
    assign w_unused_data = ^bus.DataIn;

    speech_phoneme_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PHONEME_W)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Reset_L),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (bus.DataIn[PHONEME_W-1:0]),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                          = '0;
        w_status[ST_COUNT_LSB +: CNT_W]   = w_count;
        w_status[ST_DONE]                 = r_done;
        w_status[ST_PLAYING]              = (r_play_state != P_IDLE);
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
    end

    always_comb begin
        w_rd_mux = '0;
        if (bus.RW) begin
            case (bus.Address)
                REG_DATA: w_rd_mux = w_status;
                REG_CTRL: w_rd_mux = ctrl_readback(r_irq_en);
                default:  w_rd_mux = '0;
            endcase
        end
    end

    // Read data is captured at access time so it stays stable for the whole cycle.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_bus_state <= B_IDLE;
            r_dtack_n   <= 1'b1;
            r_rd_data   <= '0;
            r_status_rd <= 1'b0;
            r_irq_en    <= 1'b0;
        end else begin
            case (r_bus_state)
                B_IDLE: begin
                    if (w_access) begin
                        r_rd_data   <= w_rd_mux;
                        r_status_rd <= bus.RW & (bus.Address == REG_DATA);
                        if (w_ctrl_wr) r_irq_en <= bus.DataIn[CTRL_IRQ_EN];
                        r_bus_state <= B_ACK;
                    end
                end
                B_ACK: begin
                    r_dtack_n   <= 1'b0;
                    r_bus_state <= B_HOLD;
                end
                B_HOLD: begin
                    if (bus.AS_L) begin
                        r_dtack_n   <= 1'b1;
                        r_rd_data   <= '0;
                        r_status_rd <= 1'b0;
                        r_bus_state <= B_IDLE;
                    end
                end
                default: r_bus_state <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_play_state <= P_IDLE;
            r_phoneme    <= '0;
        end else begin
            case (r_play_state)
                P_IDLE: begin
                    if (w_pop) begin
                        r_phoneme    <= w_head;
                        r_play_state <= P_START;
                    end
                end
                P_START: r_play_state <= P_PLAY;
                P_PLAY:  if (phoneme_speech_finish) r_play_state <= P_IDLE;
                default: r_play_state <= P_IDLE;
            endcase
        end
    end

    // A fresh end-of-utterance wins over a STATUS read clearing in the same cycle.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_done  <= 1'b0;
            r_irq_n <= 1'b1;
        end else begin
            if ((r_play_state == P_PLAY) && phoneme_speech_finish && w_empty)
                r_done <= 1'b1;
            else if (w_done_clr)
                r_done <= 1'b0;
            r_irq_n <= ~(r_done & r_irq_en);
        end
    end

    assign bus.DataOut          = r_rd_data;
    assign bus.VoiceDtack_L     = r_dtack_n;
    assign VoiceIRQ_L           = r_irq_n;
    assign phoneme_sel          = r_phoneme;
    assign start_phoneme_output = (r_play_state == P_START);

endmodule

// File: tb/tb_speech_phoneme_queue.sv
// Bench for speech_phoneme_queue: CPU bus tasks, a synthesiser responder and a
// queue-based model of the expected playback order.
module tb_speech_phoneme_queue;

    logic       Clk = 1'b0;
    logic       Reset_L;
    logic       busy;
    logic       finish;
    logic       VoiceIRQ_L;
    logic [7:0] phoneme_sel;
    logic       start_phoneme_output;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q_started[$];
    int         wide_errs = 0;
    logic       prev_start = 1'b0;
    bit         auto_fin = 1'b0;

    speech_phoneme_queue_if bus_if();

    speech_phoneme_queue #(.DEPTH(16), .PHONEME_W(8)) dut (
        .Clk                   (Clk),
        .Reset_L               (Reset_L),
        .bus                   (bus_if),
        .VoiceIRQ_L            (VoiceIRQ_L),
        .phoneme_sel           (phoneme_sel),
        .start_phoneme_output  (start_phoneme_output),
        .phoneme_speech_busy   (busy),
        .phoneme_speech_finish (finish)
    );

    always #5 Clk = ~Clk;

    // Start monitor: every start pulse logs the code presented with it.
    initial begin
        forever begin
            @(negedge Clk);
            if (start_phoneme_output === 1'b1) begin
                q_started.push_back(phoneme_sel);
                if (prev_start) wide_errs++;
            end
            prev_start = (start_phoneme_output === 1'b1);
        end
    end

    // Synthesiser model: finishes each started phoneme after a random delay.
    initial begin
        int d;
        forever begin
            @(negedge Clk);
            if (auto_fin && start_phoneme_output === 1'b1) begin
                d = $urandom_range(1, 4);
                repeat (d) @(negedge Clk);
                finish = 1'b1;
                @(negedge Clk);
                finish = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic bus_begin(input logic rw, input logic [1:0] addr, input logic [15:0] data);
        @(negedge Clk);
        bus_if.VoiceControl_H = 1'b1;
        bus_if.AS_L           = 1'b0;
        bus_if.RW             = rw;
        bus_if.LDS_L          = 1'b0;
        bus_if.Address        = addr;
        bus_if.DataIn         = data;
    endtask

    task automatic bus_wait_ack(output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk);
            #1;
            if (bus_if.VoiceDtack_L === 1'b0) begin
                lat = i;
                rd  = bus_if.DataOut;
                break;
            end
        end
    endtask

    task automatic bus_end();
        @(negedge Clk);
        bus_if.AS_L           = 1'b1;
        bus_if.VoiceControl_H = 1'b0;
        bus_if.LDS_L          = 1'b1;
        bus_if.RW             = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (bus_if.VoiceDtack_L === 1'b1) break;
        end
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [15:0] data, output int lat);
        logic [15:0] rd;
        bus_begin(1'b0, addr, data);
        bus_wait_ack(lat, rd);
        bus_end();
    endtask

    task automatic cpu_read(input logic [1:0] addr, output logic [15:0] d);
        int lat;
        bus_begin(1'b1, addr, 16'h0000);
        bus_wait_ack(lat, d);
        bus_end();
    endtask

    task automatic pulse_finish();
        @(negedge Clk);
        finish = 1'b1;
        @(negedge Clk);
        finish = 1'b0;
    endtask

    task automatic wait_starts(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (q_started.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic check_status(input string name, input logic [15:0] exp);
        logic [15:0] d;
        cpu_read(2'b00, d);
        checks++;
        if (d !== exp) begin
            failures++;
            $display("FAIL %s: STATUS actual=%h required=%h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        repeat (3) @(negedge Clk);
        checks += 5;
        if (bus_if.VoiceDtack_L !== 1'b1) begin failures++; $display("FAIL reset_dtack actual=%b required=1", bus_if.VoiceDtack_L); end
        if (VoiceIRQ_L !== 1'b1) begin failures++; $display("FAIL reset_irq actual=%b required=1", VoiceIRQ_L); end
        if (bus_if.DataOut !== 16'h0000) begin failures++; $display("FAIL reset_dataout actual=%h required=0000", bus_if.DataOut); end
        if (phoneme_sel !== 8'h00) begin failures++; $display("FAIL reset_sel actual=%h required=00", phoneme_sel); end
        if (start_phoneme_output !== 1'b0) begin failures++; $display("FAIL reset_start actual=%b required=0", start_phoneme_output); end
        Reset_L = 1'b1;
        @(negedge Clk);
        check_status("reset_status", 16'h0001);
    endtask

    task automatic test_single_write();
        int lat;
        bit ok;
        q_started.delete();
        cpu_write(2'b00, 16'h002A, lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL single_latency actual=%0d required=2", lat); end
        wait_starts(1, ok);
        checks++;
        if (!ok || q_started[0] !== 8'h2A) begin
            failures++;
            $display("FAIL single_start actual_ok=%0d sel=%h required=2a", ok, ok ? q_started[0] : 8'hxx);
        end
        @(negedge Clk);
        checks++;
        if (start_phoneme_output !== 1'b0 || phoneme_sel !== 8'h2A) begin
            failures++;
            $display("FAIL single_pulse_width start=%b sel=%h required start=0 sel=2a", start_phoneme_output, phoneme_sel);
        end
        pulse_finish();
        repeat (2) @(negedge Clk);
        check_status("single_done", 16'h0009);
    endtask

    task automatic test_three_in_order();
        logic [7:0] codes[3];
        int lat;
        int bad = 0;
        bit ok;
        q_started.delete();
        foreach (codes[i]) begin
            codes[i] = 8'($urandom_range(0, 255));
            cpu_write(2'b00, {8'h00, codes[i]}, lat);
        end
        for (int k = 0; k < 3; k++) begin
            wait_starts(k + 1, ok);
            if (!ok) bad++;
            pulse_finish();
        end
        checks++;
        if (bad != 0 || q_started.size() != 3) begin
            failures++;
            $display("FAIL three_starts actual=%0d required=3", q_started.size());
        end
        for (int k = 0; k < 3 && k < q_started.size(); k++) begin
            checks++;
            if (q_started[k] !== codes[k]) begin
                failures++;
                $display("FAIL three_order[%0d] actual=%h required=%h", k, q_started[k], codes[k]);
            end
        end
        repeat (3) @(negedge Clk);
        check_status("three_done", 16'h0009);
        check_status("three_done_cleared", 16'h0001);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  mdl[$];
        logic [7:0]  c;
        logic [15:0] rd;
        int lat;
        int bad = 0;
        bit held = 1'b1;
        bit ok;
        q_started.delete();
        busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(0, 255));
            mdl.push_back(c);
            cpu_write(2'b00, {8'($urandom_range(0, 255)), c}, lat);
            if (lat != 2) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL fill_latency bad_writes=%0d required=0", bad); end
        check_status("fill_full", 16'h1002);
        c = 8'($urandom_range(0, 255));
        mdl.push_back(c);
        bus_begin(1'b0, 2'b00, {8'h00, c});
        repeat (6) begin
            @(posedge Clk);
            #1;
            if (bus_if.VoiceDtack_L !== 1'b1) held = 1'b0;
        end
        checks++;
        if (!held) begin failures++; $display("FAIL full_waitstate dtack_held=%0d required=1", held); end
        @(negedge Clk);
        busy = 1'b0;
        bus_wait_ack(lat, rd);
        checks++;
        if (lat < 0) begin failures++; $display("FAIL full_accept actual=no_ack required=ack"); end
        bus_end();
        checks++;
        if (q_started.size() != 1 || q_started[0] !== mdl[0]) begin
            failures++;
            $display("FAIL full_first_start count=%0d required=1", q_started.size());
        end
        check_status("full_after_pop", 16'h1006);
        pulse_finish();
        auto_fin = 1'b1;
        wait_starts(17, ok);
        repeat (12) @(negedge Clk);
        auto_fin = 1'b0;
        checks++;
        if (!ok || q_started.size() != 17) begin
            failures++;
            $display("FAIL drain_count actual=%0d required=17", q_started.size());
        end
        for (int k = 0; k < 17 && k < q_started.size(); k++) begin
            checks++;
            if (q_started[k] !== mdl[k]) begin
                failures++;
                $display("FAIL drain_order[%0d] actual=%h required=%h", k, q_started[k], mdl[k]);
            end
        end
        checks++;
        if (wide_errs != 0) begin failures++; $display("FAIL start_width long_pulses=%0d required=0", wide_errs); end
        check_status("drain_done", 16'h0009);
    endtask

    task automatic test_irq();
        logic [15:0] d;
        int lat;
        bit ok;
        q_started.delete();
        cpu_write(2'b01, 16'h0002, lat);
        cpu_read(2'b01, d);
        checks++;
        if (d !== 16'h0002) begin failures++; $display("FAIL irq_ctrl_read actual=%h required=0002", d); end
        cpu_write(2'b00, {8'h00, 8'($urandom_range(0, 255))}, lat);
        wait_starts(1, ok);
        @(negedge Clk);
        checks++;
        if (!ok || VoiceIRQ_L !== 1'b1) begin failures++; $display("FAIL irq_while_playing actual=%b required=1", VoiceIRQ_L); end
        pulse_finish();
        repeat (3) @(negedge Clk);
        checks++;
        if (VoiceIRQ_L !== 1'b0) begin failures++; $display("FAIL irq_assert actual=%b required=0", VoiceIRQ_L); end
        check_status("irq_status", 16'h0009);
        repeat (2) @(negedge Clk);
        checks++;
        if (VoiceIRQ_L !== 1'b1) begin failures++; $display("FAIL irq_clear actual=%b required=1", VoiceIRQ_L); end
        cpu_write(2'b01, 16'h0000, lat);
    endtask

    task automatic test_flush();
        logic [7:0]  codes[5];
        logic [15:0] d;
        int lat;
        bit ok;
        q_started.delete();
        foreach (codes[i]) begin
            codes[i] = 8'($urandom_range(0, 255));
            cpu_write(2'b00, {8'h00, codes[i]}, lat);
        end
        wait_starts(1, ok);
        check_status("flush_before", 16'h0404);
        cpu_write(2'b01, 16'h0001, lat);
        check_status("flush_after", 16'h0005);
        cpu_read(2'b01, d);
        checks++;
        if (d !== 16'h0000) begin failures++; $display("FAIL flush_ctrl_read actual=%h required=0000", d); end
        pulse_finish();
        repeat (10) @(negedge Clk);
        checks++;
        if (q_started.size() != 1 || q_started[0] !== codes[0]) begin
            failures++;
            $display("FAIL flush_starts actual=%0d required=1", q_started.size());
        end
        check_status("flush_done", 16'h0009);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int n0;
        bus_begin(1'b0, 2'b00, {8'h00, 8'($urandom_range(0, 255))});
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (start_phoneme_output === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_reach_start actual=0 required=1"); end
        #1;
        Reset_L = 1'b0;
        #1;
        checks += 3;
        if (start_phoneme_output !== 1'b0) begin failures++; $display("FAIL rstmid_start actual=%b required=0", start_phoneme_output); end
        if (bus_if.VoiceDtack_L !== 1'b1) begin failures++; $display("FAIL rstmid_dtack actual=%b required=1", bus_if.VoiceDtack_L); end
        if (phoneme_sel !== 8'h00) begin failures++; $display("FAIL rstmid_sel actual=%h required=00", phoneme_sel); end
        @(negedge Clk);
        bus_if.AS_L           = 1'b1;
        bus_if.VoiceControl_H = 1'b0;
        bus_if.LDS_L          = 1'b1;
        bus_if.RW             = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_L = 1'b1;
        n0 = q_started.size();
        repeat (8) @(negedge Clk);
        checks++;
        if (q_started.size() != n0) begin failures++; $display("FAIL rstmid_no_start actual=%0d required=%0d", q_started.size(), n0); end
        check_status("rstmid_empty", 16'h0001);
    endtask

    initial begin
        Reset_L               = 1'b0;
        busy                  = 1'b0;
        finish                = 1'b0;
        bus_if.VoiceControl_H = 1'b0;
        bus_if.AS_L           = 1'b1;
        bus_if.RW             = 1'b1;
        bus_if.LDS_L          = 1'b1;
        bus_if.Address        = 2'b00;
        bus_if.DataIn         = 16'h0000;
        test_reset();
        test_single_write();
        test_three_in_order();
        test_back_to_back();
        test_irq();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
